// File: rtl/jesd204b_tx_link_fsm.sv
// JESD204B TX link layer, one lane, 4 octets/clk: CGS -> ILAS -> DATA.
// Optional JESD_CHAR_REPL_EN: DATA-state K28.3/K28.7 character replacement.
module jesd204b_tx_link_fsm #(
  parameter int F_OCTETS     = 2,
  parameter int K_FRAMES     = 32,
  parameter int ILAS_MF      = 4,
  parameter int SYNC_LOW_CYC = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sync_n,
  input  logic [31:0]  s_d_in,
  input  logic [111:0] cfg_octets,
  output logic [31:0]  tx_data,
  output logic [3:0]   tx_charisk,
  output logic         data_valid,
  output logic [1:0]   link_state,
  output logic [7:0]   lmfc_cnt
);

  localparam int MF_OCT     = F_OCTETS * K_FRAMES;
  localparam int MF_WORDS   = MF_OCT / 4;
  localparam int ILAS_WORDS = ILAS_MF * MF_WORDS;
  localparam int IW         = $clog2(ILAS_WORDS) + 1;
  localparam int SW         = $clog2(SYNC_LOW_CYC + 1);

  localparam logic [7:0]    LMFC_LAST = 8'(MF_WORDS - 1);
  localparam logic [7:0]    P_LAST    = 8'(MF_OCT - 1);
  localparam logic [IW-1:0] ILAS_LAST = IW'(ILAS_WORDS - 1);
  localparam logic [IW-1:0] MF1_LO    = IW'(MF_WORDS);
  localparam logic [IW-1:0] MF1_HI    = IW'(2 * MF_WORDS);
  localparam logic [SW-1:0] SYNC_TRIG = SW'(SYNC_LOW_CYC - 1);
  localparam logic [SW-1:0] SYNC_SAT  = SW'(SYNC_LOW_CYC);

  typedef enum logic [1:0] {
    CGS  = 2'd0,
    ILAS = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    lmfc_nxt;
  logic [IW-1:0] ilas_cnt;
  logic [IW-1:0] ilas_nxt;
  logic [SW-1:0] sync_cnt;
  logic [SW-1:0] sync_nxt;
  logic          resync;
  logic          mf1;
  logic [31:0]   data_nxt;
  logic [3:0]    k_nxt;
  logic [7:0]    p;
  logic [7:0]    oct;
  logic          ok;
  logic [7:0]    cfg_b [16];
`ifdef JESD_CHAR_REPL_EN
  localparam logic [7:0] F_MASK = 8'(F_OCTETS - 1);
  logic [7:0]    pe;
`endif

  assign link_state = state;

  // Unpack ILAS config octets into a byte table indexed by octet number
  always_comb begin
    for (int n = 0; n < 16; n++) begin
      cfg_b[n] = 8'h00;
    end
    for (int n = 0; n < 14; n++) begin
      cfg_b[n] = cfg_octets[111-8*n -: 8];
    end
  end

  // Next-state, LMFC/ILAS/sync counters
  always_comb begin
    state_nxt = state;
    ilas_nxt  = '0;
    lmfc_nxt  = (lmfc_cnt == LMFC_LAST) ? 8'd0
                                        : lmfc_cnt + 8'd1;
    resync    = (state != CGS) && !sync_n &&
                (sync_cnt >= SYNC_TRIG);
    if (state == CGS || sync_n) begin
      sync_nxt = '0;
    end else if (sync_cnt == SYNC_SAT) begin
      sync_nxt = sync_cnt;
    end else begin
      sync_nxt = sync_cnt + SW'(1);
    end
    unique case (state)
      CGS: begin
        if (sync_n && lmfc_cnt == LMFC_LAST) begin
          state_nxt = ILAS;
        end
      end
      ILAS: begin
        if (resync) begin
          state_nxt = CGS;
        end else if (ilas_cnt == ILAS_LAST) begin
          state_nxt = DATA;
        end else begin
          ilas_nxt = ilas_cnt + IW'(1);
        end
      end
      DATA: begin
        if (resync) begin
          state_nxt = CGS;
        end
      end
      default: state_nxt = CGS;
    endcase
  end

  // Build the word that will be on the wire alongside the next state
  always_comb begin
    data_nxt = 32'hBCBCBCBC;
    k_nxt    = 4'hF;
    p        = '0;
    oct      = '0;
    ok       = 1'b0;
    mf1      = (ilas_nxt >= MF1_LO) && (ilas_nxt < MF1_HI);
`ifdef JESD_CHAR_REPL_EN
    pe       = '0;
`endif
    unique case (state_nxt)
      ILAS: begin
        for (int i = 0; i < 4; i++) begin
          p   = 8'({lmfc_nxt, 2'b00}) + 8'(i);
          oct = p;
          ok  = 1'b0;
          if (p == 8'd0) begin
            oct = 8'h1C;
            ok  = 1'b1;
          end else if (p == P_LAST) begin
            oct = 8'h7C;
            ok  = 1'b1;
          end else if (mf1 && p == 8'd1) begin
            oct = 8'h9C;
            ok  = 1'b1;
          end else if (mf1 && p <= 8'd15) begin
            oct = cfg_b[p[3:0] - 4'd2];
          end
          data_nxt[8*(3-i) +: 8] = oct;
          k_nxt[3-i]             = ok;
        end
      end
      DATA: begin
        data_nxt = s_d_in;
        k_nxt    = 4'h0;
`ifdef JESD_CHAR_REPL_EN
        for (int i = 0; i < 4; i++) begin
          p   = 8'({lmfc_nxt, 2'b00}) + 8'(i);
          pe  = p + 8'd1;
          oct = s_d_in[8*(3-i) +: 8];
          unique case (1'b1)
            (p == P_LAST && oct == 8'h7C):
              k_nxt[3-i] = 1'b1;
            (p != P_LAST && (pe & F_MASK) == 8'd0 &&
             oct == 8'hFC):
              k_nxt[3-i] = 1'b1;
            default: ;
          endcase
        end
`endif
      end
      default: ;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CGS;
      lmfc_cnt   <= '0;
      ilas_cnt   <= '0;
      sync_cnt   <= '0;
      tx_data    <= 32'hBCBCBCBC;
      tx_charisk <= 4'hF;
      data_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      lmfc_cnt   <= lmfc_nxt;
      ilas_cnt   <= ilas_nxt;
      sync_cnt   <= sync_nxt;
      tx_data    <= data_nxt;
      tx_charisk <= k_nxt;
      data_valid <= (state_nxt == DATA);
    end
  end

endmodule

// File: tb/tb_jesd204b_tx_link_fsm.sv
// Bench for jesd204b_tx_link_fsm (F=2, K=32, ILAS_MF=4).
// Scoreboard of expected words, popped one clock after drive.
module tb_jesd204b_tx_link_fsm;

  logic         clk = 1'b0;
  logic         reset;
  logic         sync_n;
  logic [31:0]  s_d_in;
  logic [111:0] cfg;
  logic [31:0]  tx_data;
  logic [3:0]   tx_charisk;
  logic         data_valid;
  logic [1:0]   link_state;
  logic [7:0]   lmfc_cnt;

  always #5 clk = ~clk;

  jesd204b_tx_link_fsm #(
    .F_OCTETS(2),
    .K_FRAMES(32),
    .ILAS_MF(4),
    .SYNC_LOW_CYC(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sync_n(sync_n),
    .s_d_in(s_d_in),
    .cfg_octets(cfg),
    .tx_data(tx_data),
    .tx_charisk(tx_charisk),
    .data_valid(data_valid),
    .link_state(link_state),
    .lmfc_cnt(lmfc_cnt)
  );

`ifdef JESD_CHAR_REPL_EN
  localparam logic [3:0] K_EOMF = 4'h5;
`else
  localparam logic [3:0] K_EOMF = 4'h0;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        dv;
    logic [1:0]  ls;
  } exp_t;

  exp_t       sb[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] lm     = 8'd0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
    if (reset) lm = 8'd0;
    else lm = (lm == 8'd15) ? 8'd0 : lm + 8'd1;
  endtask

  function automatic exp_t cgs_e();
    exp_t e;
    e.d  = 32'hBCBCBCBC;
    e.k  = 4'hF;
    e.dv = 1'b0;
    e.ls = 2'd0;
    return e;
  endfunction

  function automatic exp_t data_e(input logic [31:0] d,
                                  input logic [3:0] k);
    exp_t e;
    e.d  = d;
    e.k  = k;
    e.dv = 1'b1;
    e.ls = 2'd2;
    return e;
  endfunction

  function automatic exp_t ilas_e(input int w);
    exp_t        e;
    logic [31:0] dd;
    logic [3:0]  kv;
    logic [7:0]  o;
    logic        kk;
    int          mf;
    int          p;
    mf = w / 16;
    dd = '0;
    kv = '0;
    for (int i = 0; i < 4; i++) begin
      p  = (w % 16) * 4 + i;
      o  = 8'(p);
      kk = 1'b0;
      if (p == 0) begin
        o  = 8'h1C;
        kk = 1'b1;
      end else if (p == 63) begin
        o  = 8'h7C;
        kk = 1'b1;
      end else if (mf == 1 && p == 1) begin
        o  = 8'h9C;
        kk = 1'b1;
      end else if (mf == 1 && p >= 2 && p <= 15) begin
        o = 8'hA0 + 8'(p - 2);
      end
      dd[31-8*i -: 8] = o;
      kv[3-i]         = kk;
    end
    e.d  = dd;
    e.k  = kv;
    e.dv = 1'b0;
    e.ls = 2'd1;
    return e;
  endfunction

  function automatic logic [31:0] rnd();
    return $urandom & 32'h3F3F3F3F;
  endfunction

  task automatic step(input string tag,
                      input logic [31:0] d,
                      input exp_t e);
    exp_t got;
    s_d_in = d;
    sb.push_back(e);
    clk1();
    got = sb.pop_front();
    chk(tag,
        64'({tx_data, tx_charisk, data_valid,
             link_state, lmfc_cnt}),
        64'({got, lm}));
  endtask

  initial begin
    reset  = 1'b1;
    sync_n = 1'b0;
    s_d_in = '0;
    cfg    = '0;
    for (int n = 0; n < 14; n++) begin
      cfg[111-8*n -: 8] = 8'hA0 + 8'(n);
    end

    step("reset", 32'h12345678, cgs_e());
    reset = 1'b0;

    repeat (100) step("cgs_hold", rnd(), cgs_e());
    while (lm != 8'd5) step("cgs_wait", rnd(), cgs_e());
    sync_n = 1'b1;
    while (lm != 8'd15) step("cgs_align", rnd(), cgs_e());

    for (int w = 0; w < 64; w++) begin
      step("ilas", rnd(), ilas_e(w));
      if (w == 0)
        chk("ilas_w0",
            64'({tx_data, tx_charisk, lmfc_cnt}),
            64'({32'h1C010203, 4'h8, 8'd0}));
      if (w == 15)
        chk("ilas_w15",
            64'({tx_data, tx_charisk}),
            64'({32'h3C3D3E7C, 4'h1}));
      if (w == 16)
        chk("ilas_mf1_w0",
            64'({tx_data, tx_charisk}),
            64'({32'h1C9CA0A1, 4'hC}));
    end

    step("data_first", 32'hDEADBEEF,
         data_e(32'hDEADBEEF, 4'h0));
    repeat (5) begin
      s_d_in = rnd();
      step("data", s_d_in, data_e(s_d_in, 4'h0));
    end

    sync_n = 1'b0;
    repeat (3) begin
      s_d_in = rnd();
      step("data_low3", s_d_in, data_e(s_d_in, 4'h0));
    end
    sync_n = 1'b1;
    repeat (3) begin
      s_d_in = rnd();
      step("data_after3", s_d_in, data_e(s_d_in, 4'h0));
    end
    sync_n = 1'b0;
    repeat (3) begin
      s_d_in = rnd();
      step("data_low_pre", s_d_in, data_e(s_d_in, 4'h0));
    end
    step("resync_data", rnd(), cgs_e());

    sync_n = 1'b1;
    while (lm != 8'd15) step("cgs_realign", rnd(), cgs_e());
    for (int w = 0; w <= 30; w++) begin
      step("ilas_re", rnd(), ilas_e(w));
      if (w == 0)
        chk("ilas_re_lmfc0", 64'(lmfc_cnt), 64'(8'd0));
    end

    reset = 1'b1;
    step("mid_reset", rnd(), cgs_e());
    reset = 1'b0;
    while (lm != 8'd15) step("cgs_post_rst", rnd(), cgs_e());

    for (int w = 0; w < 64; w++) begin
      sync_n = (w >= 61) ? 1'b0 : 1'b1;
      step("ilas_last", rnd(), ilas_e(w));
    end
    step("resync_final_ilas", rnd(), cgs_e());

    sync_n = 1'b1;
    while (lm != 8'd15) step("cgs_again", rnd(), cgs_e());
    for (int w = 0; w < 64; w++) begin
      step("ilas_full", rnd(), ilas_e(w));
    end
    do begin
      s_d_in = rnd();
      step("data_run", s_d_in, data_e(s_d_in, 4'h0));
    end while (lm != 8'd14);
    step("repl_eomf", 32'h00FC007C,
         data_e(32'h00FC007C, K_EOMF));
    while (lm != 8'd2) begin
      s_d_in = rnd();
      step("data_run2", s_d_in, data_e(s_d_in, 4'h0));
    end
    step("repl_mid", 32'h0000007C,
         data_e(32'h0000007C, 4'h0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
